nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: NIB, default 4, number of 4-bit slices; data width W = 4*NIB (16 at default).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry into nibble 0.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  W  registered result.
REQ-012 cout  output  1  registered carry out of nibble NIB-1.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL equal 1 only in IDLE; an accept is in_valid && in_ready at a rising edge.
REQ-016 On accept, a, b and cin SHALL be captured into internal registers; the nibble index SHALL clear to 0; the carry register SHALL load cin; the state SHALL go to RUN.
REQ-017 Each RUN cycle SHALL add nibble[idx] of the captured A and B plus the carry register through one 4-bit carry-lookahead slice.
REQ-018 Each RUN cycle SHALL write the slice sum into sum[4*idx+3:4*idx], load the slice carry-out into the carry register, and increment idx.
REQ-019 When idx = NIB-1 in RUN, the next edge SHALL go to DONE, set out_valid = 1 and load cout from the final slice carry-out.
REQ-020 Latency: if an accept occurs at edge k, out_valid SHALL be high after edge k+NIB (4 at default).
REQ-021 In DONE, sum, cout and out_valid SHALL hold stable while out_ready = 0.
REQ-022 In DONE, out_ready = 1 at an edge SHALL clear out_valid and return to IDLE; no accept is possible in that same cycle.
REQ-023 Maximum throughput SHALL be one operation per NIB+2 cycles.
REQ-024 Changes on a, b or cin after accept SHALL NOT affect the result in progress.
REQ-025 in_valid while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 Arithmetic SHALL be modulo 2^W; the carry SHALL appear only on cout; partially written sum bits are not meaningful until out_valid = 1.
REQ-027 The slice carry SHALL be used only within the cycle that computes it; no combinational path SHALL exist from in_valid or out_ready to sum or cout.

Reset
REQ-028 While rst_n = 0, the state SHALL be IDLE and in_ready SHALL be 1.
REQ-029 While rst_n = 0, out_valid, busy, sum, cout, idx, the carry register and the operand registers SHALL all be 0.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation immediately with no result delivered.
REQ-031 After reset release, the block SHALL accept on the first edge with in_valid = 1.

Structure
REQ-032 A shared package adder_pkg SHALL hold the state enum (IDLE/RUN/DONE), the slice width constant 4 and the default NIB.
REQ-033 The block SHALL instantiate exactly one sub-module, the existing 4-bit carry-lookahead slice carry_la_adder; no other arithmetic SHALL be inferred on the data path.
REQ-034 The nibble index SHALL be ceil(log2(NIB)) bits wide, minimum 1.

Verification
REQ-035 Basic add: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid high 4 cycles after accept.
REQ-036 Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1.
REQ-037 Carry-in only: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; also a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0.
REQ-038 Backpressure: a=0x8000, b=0x8000, out_ready held 0 for 5 cycles -> sum=0x0000, cout=1, both stable with out_valid high, and in_ready stays 0 throughout; release out_ready -> IDLE next cycle.
REQ-039 Busy ignore: after accepting 0x0001+0x0001, drive in_valid=1 with a=0xAAAA during RUN -> result 0x0002, and exactly one result is delivered.
REQ-040 Mid-op reset: pulse rst_n low 2 cycles into RUN -> all outputs 0 and in_ready 1 immediately; a new op 0x0F0F+0x0101 then yields 0x1010, cout=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   SLICE_W     : width of one arithmetic slice (a nibble)
//   NIB_DEFAULT : default number of slices in an operand
//   state_e     : controller states IDLE / RUN / DONE
//   idx_width() : width of the nibble index for a given slice count
package adder_pkg;

   localparam int SLICE_W     = 4;
   localparam int NIB_DEFAULT = 4;

   // Fixed encodings so the states can also be referred to as plain constants.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

   // ceil(log2(nib)), never less than one bit.
   function automatic int idx_width(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand / result handshake bundle for nibble_serial_adder.
//   in_valid/in_ready : operand set handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy : block is in RUN or DONE
// Modports: master = operand producer / result consumer, slave = the adder.
interface nibble_serial_adder_if
   import adder_pkg::*;
#(
   parameter int NIB = NIB_DEFAULT
);
   localparam int W = SLICE_W * NIB;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );

endinterface

// File: rtl/carry_la_adder.sv
// 4-bit carry-lookahead adder slice.
//   a, b : slice operands
//   cin  : carry into bit 0
//   s    : slice sum
//   cout : carry out of bit 3
// Every internal carry is formed directly from generate/propagate terms.
module carry_la_adder
   import adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   generate
      for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_sum
         assign s[gi] = p[gi] ^ c[gi];
      end
   endgenerate

   assign cout = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: accepts a W-bit operand pair plus carry-in, adds one
// nibble per cycle through a single carry-lookahead slice, and presents the
// registered sum and carry-out until the consumer takes them.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : operand/result handshake (slave side), see nibble_serial_adder_if
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int NIB = NIB_DEFAULT
)(
   input  logic                  clk,
   input  logic                  rst_n,
   nibble_serial_adder_if.slave  bus
);

   localparam int W    = SLICE_W * NIB;
   localparam int IDXW = idx_width(NIB);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

   state_e          state_q,     state_d;
   logic [W-1:0]    a_q,         a_d;
   logic [W-1:0]    b_q,         b_d;
   logic            carry_q,     carry_d;
   logic [IDXW-1:0] idx_q,       idx_d;
   logic [W-1:0]    sum_q,       sum_d;
   logic            cout_q,      cout_d;
   logic            out_valid_q, out_valid_d;

   logic [SLICE_W-1:0] slice_s;
   logic               slice_cout;

   // Bit offset of the current nibble: idx * 4.
   logic [IDXW+1:0] bit_ofs;
   assign bit_ofs = {idx_q, 2'b00};

   carry_la_adder u_slice (
      .a    (a_q[bit_ofs +: SLICE_W]),
      .b    (b_q[bit_ofs +: SLICE_W]),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_cout)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[bit_ofs +: SLICE_W] = slice_s;
            carry_d = slice_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d       = '0;
               cout_d      = slice_cout;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            // Result is held untouched until the consumer takes it.
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed corner cases followed
// by random operand sets compared against a plain-arithmetic reference.
module tb_nibble_serial_adder;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   nibble_serial_adder_if #(.NIB(NIB)) bus ();

   nibble_serial_adder #(.NIB(NIB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-width addition, carry taken from bit W.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic c);
      logic [W:0] r;
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction: present operands, scramble inputs while the
   // block works, hold out_ready low for 'hold' cycles, then take the result.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int hold, input bit noise,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = c;
      check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      for (int i = 1; i <= NIB; i++) begin
         @(negedge clk);
         // Inputs after accept must not disturb the operation.
         bus.in_valid = noise;
         bus.a        = noise ? 16'hAAAA : W'($urandom);
         bus.b        = W'($urandom);
         bus.cin      = 1'($urandom);
         if (i < NIB) begin
            check("run_out_valid", 32'(bus.out_valid), 32'd0);
            check("run_in_ready", 32'(bus.in_ready), 32'd0);
            check("run_busy", 32'(bus.busy), 32'd1);
         end
         if (i < NIB) @(posedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("done_out_valid", 32'(bus.out_valid), 32'd1);
      check("done_sum", 32'(bus.sum), 32'(exp_sum));
      check("done_cout", 32'(bus.cout), 32'(exp_cout));
      check("done_in_ready", 32'(bus.in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         bus.out_ready = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_sum", 32'(bus.sum), 32'(exp_sum));
         check("hold_cout", 32'(bus.cout), 32'(exp_cout));
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("release_out_valid", 32'(bus.out_valid), 32'd0);
      check("release_in_ready", 32'(bus.in_ready), 32'd1);
      check("release_busy", 32'(bus.busy), 32'd0);
      $display("op a=%04h b=%04h cin=%0d hold=%0d -> sum=%04h cout=%0d",
               a, b, c, hold, exp_sum, exp_cout);
      if (noise) begin
         // Requests made while busy must not have been queued.
         @(posedge clk);
         @(negedge clk);
         check("no_queued_op", 32'(bus.busy), 32'd0);
         check("no_second_result", 32'(bus.out_valid), 32'd0);
      end
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic [W:0]   r;

      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;

      repeat (2) @(negedge clk);
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_sum", 32'(bus.sum), 32'd0);
      check("reset_cout", 32'(bus.cout), 32'd0);
      rst_n = 1'b1;

      // Directed cases with known results.
      do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 16'h5555, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 16'h0000, 1'b1);
      do_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 1'b1);
      do_op(16'h00FF, 16'h0001, 1'b0, 1, 1'b0, 16'h0100, 1'b0);
      do_op(16'h8000, 16'h8000, 1'b0, 5, 1'b0, 16'h0000, 1'b1);
      do_op(16'h0001, 16'h0001, 1'b0, 0, 1'b1, 16'h0002, 1'b0);

      // Reset two cycles into RUN aborts the operation at once.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 16'h1111;
      bus.b        = 16'h2222;
      bus.cin      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_sum", 32'(bus.sum), 32'd0);
      check("abort_cout", 32'(bus.cout), 32'd0);
      $display("reset asserted mid-operation");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_op(16'h0F0F, 16'h0101, 1'b0, 0, 1'b0, 16'h1010, 1'b0);

      // Random operand sets against the reference model.
      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         r  = ref_add(ra, rb, rc);
         do_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom),
               r[W-1:0], r[W]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
